// File: rtl/seq_divider.sv
// seq_divider: 32-bit restoring shift-subtract divider, 33-cycle latency.
// Optional macro DIV_SIGNED_EN adds signed_op and truncating signed division.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic        signed_op,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem_r;
  logic [31:0] q_r;
  logic [31:0] dvs_r;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic        sgn;
`ifdef DIV_SIGNED_EN
  assign sgn = signed_op;
`else
  assign sgn = 1'b0;
`endif

  // Signed operation divides magnitudes and fixes signs on the way out.
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign neg_a = sgn & dividend[31];
  assign neg_b = sgn & divisor[31];
  assign mag_a = neg_a ? (~dividend + 32'd1) : dividend;
  assign mag_b = neg_b ? (~divisor + 32'd1) : divisor;

  logic [32:0] shl;
  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] q_nx;

  assign shl    = {rem_r, q_r[31]};
  assign trial  = shl - {1'b0, dvs_r};
  assign rem_nx = trial[32] ? shl[31:0] : trial[31:0];
  assign q_nx   = {q_r[30:0], ~trial[32]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
      div_zero  <= 1'b0;
      cnt       <= 5'd0;
      rem_r     <= 32'd0;
      q_r       <= 32'd0;
      dvs_r     <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            cnt      <= 5'd0;
            if (divisor == 32'd0) begin
              q_r   <= 32'hFFFF_FFFF;
              rem_r <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              q_r   <= mag_a;
              rem_r <= 32'd0;
              dvs_r <= mag_b;
              neg_q <= neg_a ^ neg_b;
              neg_r <= neg_a;
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          busy  <= 1'b1;
          rem_r <= rem_nx;
          q_r   <= q_nx;
          if (cnt == 5'd31) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          quotient  <= neg_q ? (~q_r + 32'd1) : q_r;
          remainder <= neg_r ? (~rem_r + 32'd1) : rem_r;
          div_zero  <= dz;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider latency, results and reset.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one division, then watch up to 40 cycles for its done pulse.
  task automatic run_div(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic sg,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int dc;
    int nd;
    dc = -1;
    nd = 0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    signed_op = sg;
`else
    if (sg) $display("note: signed vector skipped");
`endif
    tick();
    start    = 1'b0;
    dividend = 32'hA5A5_5A5A;
    divisor  = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        nd++;
        if (dc < 0) dc = i;
      end
    end
    check({tag, "_lat"}, dc, elat);
    check({tag, "_ndone"}, nd, 1);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
  endtask

  initial begin
    int dc;
    int bc;
    int nd;
    int d1;
    int d2;
    logic [31:0] q1;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
`ifdef DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);

    // 100 / 7 with busy-length measurement
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    tick();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd0;
    dc = -1;
    bc = 0;
    nd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy) bc++;
      if (done) begin
        nd++;
        if (dc < 0) dc = i;
        check("u100_busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    check("u100_lat", dc, 33);
    check("u100_busy_cycles", bc, 32);
    check("u100_ndone", nd, 1);
    check("u100_q", quotient, 32'd14);
    check("u100_r", remainder, 32'd2);
    check("u100_dz", {31'd0, div_zero}, 32'd0);

    run_div("dz", 32'h1234_5678, 32'd0, 1'b0,
            32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    run_div("big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0,
            32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 33);
    run_div("small", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33);
    run_div("dz2", 32'hCAFE_0001, 32'd0, 1'b0,
            32'hFFFF_FFFF, 32'hCAFE_0001, 1'b1, 1);

    // ignored start during RUN; accepting start clears div_zero
    start    = 1'b1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    tick();
    check("ign_dz_clr", {31'd0, div_zero}, 32'd0);
    dc = -1;
    nd = 0;
    for (int i = 1; i <= 40; i++) begin
      start    = (i == 5);
      dividend = 32'd9;
      divisor  = 32'd3;
      tick();
      if (done) begin
        nd++;
        if (dc < 0) dc = i;
      end
    end
    start = 1'b0;
    check("ign_lat", dc, 33);
    check("ign_ndone", nd, 1);
    check("ign_q", quotient, 32'hFFFF_FFFF);
    check("ign_r", remainder, 32'd0);

    // reset mid-RUN aborts with no done pulse
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_q", quotient, 32'd0);
    check("mid_r", remainder, 32'd0);
    check("mid_dz", {31'd0, div_zero}, 32'd0);
    nd = 0;
    bc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) nd++;
      if (busy) bc++;
    end
    check("mid_ndone", nd, 0);
    check("mid_nbusy", bc, 0);

    // reset wins over start on the same edge
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd0;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    nd = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (done) nd++;
    end
    check("prio_ndone", nd, 0);
    check("prio_dz", {31'd0, div_zero}, 32'd0);

    // back-to-back with start held high
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    tick();
    d1 = -1;
    d2 = -1;
    nd = 0;
    q1 = 32'd0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (done) begin
        nd++;
        if (d1 < 0) begin
          d1 = i;
          q1 = quotient;
        end else if (d2 < 0) begin
          d2 = i;
        end
      end
    end
    start = 1'b0;
    check("b2b_first", d1, 33);
    check("b2b_second", d2, 67);
    check("b2b_ndone", nd, 2);
    check("b2b_q1", q1, 32'd10);
    check("b2b_q", quotient, 32'd10);
    check("b2b_r", remainder, 32'd0);
    for (int i = 1; i <= 40; i++) tick();

`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
            32'h8000_0000, 32'd0, 1'b0, 33);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
            32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0,
            32'h7FFF_FFFC, 32'd1, 1'b0, 33);
    run_div("s_dz", 32'hFFFF_FFF0, 32'd0, 1'b1,
            32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
